// File: rtl/complex_mxv_result_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | complex_mxv_result_packer                                                   |
// | Packs NO_OF_UNITS scalar complex results per word into the AP total memory. |
// | Optional: CPACK_ZERO_PAD_EN zero-pads partial words and adds pad_mask.      |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module complex_mxv_result_packer #(
   parameter int ELEMENT_WIDTH = 64,
   parameter int NO_OF_UNITS   = 8,
   parameter int ADDR_W        = 10
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [31:0]                            total,
   input  logic [ADDR_W-1:0]                      base_addr,
   input  logic [ELEMENT_WIDTH-1:0]               result_in,
   input  logic                                   result_valid,
   output logic                                   mem_we,
   output logic [ADDR_W-1:0]                      mem_addr,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   mem_wdata,
   output logic                                   busy,
   output logic                                   done,
   output logic [31:0]                            count,
   output logic                                   err
`ifdef CPACK_ZERO_PAD_EN
   ,
   output logic [NO_OF_UNITS-1:0]                 pad_mask
`endif
);

   localparam int c_WORD_W = ELEMENT_WIDTH * NO_OF_UNITS;
   localparam int c_LANE_W = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1;
   localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(NO_OF_UNITS - 1);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_COLLECT = 2'd1;
   localparam logic [1:0] c_DONE    = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [31:0]           total_q, total_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [c_LANE_W-1:0]   lane_idx_q, lane_idx_d;
   logic [31:0]           count_q, count_d;
   logic [c_WORD_W-1:0]   buf_q, buf_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [c_WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                  err_q, err_d;
`ifdef CPACK_ZERO_PAD_EN
   logic [NO_OF_UNITS-1:0] pad_mask_q, pad_mask_d;
`endif

   logic                  w_start;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_flush;
   logic [c_WORD_W-1:0]   w_buf_fill;

   assign w_start  = start && (state_q != c_COLLECT);
   assign w_accept = result_valid && (state_q == c_COLLECT);
   assign w_last   = w_accept && ((count_q + 32'd1) == total_q);
   assign w_flush  = w_accept && ((lane_idx_q == c_LAST_LANE) || w_last);

   // Lane buffer with the incoming element already merged, so a flush sees it.
   always_comb begin
      w_buf_fill = buf_q;
      if (w_accept) begin
         w_buf_fill[lane_idx_q*ELEMENT_WIDTH +: ELEMENT_WIDTH] = result_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE, c_DONE: begin
            if (start) begin
               state_d = (total == 32'd0) ? c_DONE : c_COLLECT;
            end
         end
         c_COLLECT: begin
            if (w_last) begin
               state_d = c_DONE;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         c_COLLECT: busy = 1'b1;
         c_DONE:    done = 1'b1;
         default:   ;
      endcase
   end

   always_comb begin
      total_d     = total_q;
      addr_d      = addr_q;
      lane_idx_d  = lane_idx_q;
      count_d     = count_q;
      buf_d       = w_buf_fill;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;
`ifdef CPACK_ZERO_PAD_EN
      pad_mask_d  = '0;
`endif
      if (w_start) begin
         total_d    = total;
         addr_d     = base_addr;
         lane_idx_d = '0;
         count_d    = 32'd0;
         err_d      = 1'b0;
      end else if (result_valid && (state_q != c_COLLECT)) begin
         err_d = 1'b1;
      end

      if (w_accept) begin
         count_d = count_q + 32'd1;
         if (w_flush) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = w_buf_fill;
            addr_d      = addr_q + ADDR_W'(1);
            lane_idx_d  = '0;
`ifdef CPACK_ZERO_PAD_EN
            buf_d       = '0;
            for (int k = 0; k < NO_OF_UNITS; k++) begin
               pad_mask_d[k] = (k <= int'(lane_idx_q));
            end
`endif
         end else begin
            lane_idx_d = lane_idx_q + c_LANE_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         total_q     <= '0;
         addr_q      <= '0;
         lane_idx_q  <= '0;
         count_q     <= '0;
         buf_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
`ifdef CPACK_ZERO_PAD_EN
         pad_mask_q  <= '0;
`endif
      end else begin
         total_q     <= total_d;
         addr_q      <= addr_d;
         lane_idx_q  <= lane_idx_d;
         count_q     <= count_d;
         buf_q       <= buf_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         err_q       <= err_d;
`ifdef CPACK_ZERO_PAD_EN
         pad_mask_q  <= pad_mask_d;
`endif
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign count     = count_q;
   assign err       = err_q;
`ifdef CPACK_ZERO_PAD_EN
   assign pad_mask  = pad_mask_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_complex_mxv_result_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_complex_mxv_result_packer                                                |
// | Directed self-checking bench for complex_mxv_result_packer.                 |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_complex_mxv_result_packer;

   localparam int EW = 64;
   localparam int NU = 8;
   localparam int AW = 10;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [31:0]     total;
   logic [AW-1:0]   base_addr;
   logic [EW-1:0]   result_in;
   logic            result_valid;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [EW*NU-1:0] mem_wdata;
   logic            busy;
   logic            done;
   logic [31:0]     count;
   logic            err;
`ifdef CPACK_ZERO_PAD_EN
   logic [NU-1:0]   pad_mask;
`endif

   always #5 clk = ~clk;

   complex_mxv_result_packer #(
      .ELEMENT_WIDTH (EW),
      .NO_OF_UNITS   (NU),
      .ADDR_W        (AW)
   ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .total        (total),
      .base_addr    (base_addr),
      .result_in    (result_in),
      .result_valid (result_valid),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done),
      .count        (count),
      .err          (err)
`ifdef CPACK_ZERO_PAD_EN
      ,
      .pad_mask     (pad_mask)
`endif
   );

   typedef struct {
      logic [AW-1:0]    addr;
      logic [EW*NU-1:0] data;
      logic [NU-1:0]    pm;
   } wr_t;

   wr_t wq[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   // Every memory write observed on the port, in order.
   always @(negedge clk) begin
      wr_t w;
      if (mem_we === 1'b1) begin
         w.addr = mem_addr;
         w.data = mem_wdata;
`ifdef CPACK_ZERO_PAD_EN
         w.pm   = pad_mask;
`else
         w.pm   = '0;
`endif
         wq.push_back(w);
      end
   end

   task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input int re, input int im);
      return {re[31:0], im[31:0]};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_start(input int t, input logic [AW-1:0] b);
      start     = 1'b1;
      total     = t;
      base_addr = b;
      tick();
      start     = 1'b0;
   endtask

   task automatic send(input logic [63:0] v, input int gap);
      result_valid = 1'b1;
      result_in    = v;
      tick();
      result_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic check_idle_zero(input string pfx);
      check_eq({pfx, "_mem_we"},    512'(mem_we),    512'(0));
      check_eq({pfx, "_mem_addr"},  512'(mem_addr),  512'(0));
      check_eq({pfx, "_mem_wdata"}, 512'(mem_wdata), 512'(0));
      check_eq({pfx, "_busy"},      512'(busy),      512'(0));
      check_eq({pfx, "_done"},      512'(done),      512'(0));
      check_eq({pfx, "_count"},     512'(count),     512'(0));
      check_eq({pfx, "_err"},       512'(err),       512'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [511:0] e;
      reset        = 1'b1;
      start        = 1'b0;
      total        = '0;
      base_addr    = '0;
      result_in    = '0;
      result_valid = 1'b0;
      repeat (2) tick();
      check_idle_zero("rst");
      reset = 1'b0;
      tick();

      // Full words, back-to-back
      wq.delete();
      do_start(16, 10'h010);
      check_eq("t1_busy", 512'(busy), 512'(1));
      for (int i = 0; i < 16; i++) send(mk(i, 0), 0);
      check_eq("t1_done",   512'(done),   512'(1));
      check_eq("t1_we_in_done", 512'(mem_we), 512'(1));
      check_eq("t1_count",  512'(count),  512'(16));
      check_eq("t1_err",    512'(err),    512'(0));
      check_eq("t1_busy_off", 512'(busy), 512'(0));
      repeat (3) tick();
      check_eq("t1_nwrites", 512'(wq.size()), 512'(2));
      for (int n = 0; n < 2; n++) begin
         for (int k = 0; k < NU; k++) e[k*64 +: 64] = mk(8*n + k, 0);
         if (wq.size() > n) begin
            check_eq($sformatf("t1_addr%0d", n), 512'(wq[n].addr), 512'(10'h010 + n));
            check_eq($sformatf("t1_data%0d", n), wq[n].data, e);
         end
      end

      // Partial final word, gapped valid
      wq.delete();
      do_start(11, 10'h020);
      for (int i = 0; i < 11; i++) send(mk(100 + i, i), 2);
      check_eq("t2_done",    512'(done),  512'(1));
      check_eq("t2_count",   512'(count), 512'(11));
      check_eq("t2_nwrites", 512'(wq.size()), 512'(2));
      for (int k = 0; k < NU; k++) e[k*64 +: 64] = mk(100 + k, k);
      if (wq.size() > 0) begin
         check_eq("t2_addr0", 512'(wq[0].addr), 512'(10'h020));
         check_eq("t2_data0", wq[0].data, e);
      end
      for (int k = 0; k < NU; k++) begin
`ifdef CPACK_ZERO_PAD_EN
         e[k*64 +: 64] = (k < 3) ? mk(108 + k, 8 + k) : 64'd0;
`else
         e[k*64 +: 64] = (k < 3) ? mk(108 + k, 8 + k) : mk(100 + k, k);
`endif
      end
      if (wq.size() > 1) begin
         check_eq("t2_addr1", 512'(wq[1].addr), 512'(10'h021));
         check_eq("t2_data1", wq[1].data, e);
`ifdef CPACK_ZERO_PAD_EN
         check_eq("t2_pm0", 512'(wq[0].pm), 512'(8'hFF));
         check_eq("t2_pm1", 512'(wq[1].pm), 512'(8'h07));
`endif
      end

      // Spurious valid in IDLE, total=0, spurious valid in DONE
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wq.delete();
      send(mk(5, 5), 0);
      check_eq("t3_err_idle",   512'(err),   512'(1));
      check_eq("t3_count_idle", 512'(count), 512'(0));
      check_eq("t3_busy_idle",  512'(busy),  512'(0));
      check_eq("t3_done_idle",  512'(done),  512'(0));
      do_start(0, 10'h100);
      check_eq("t3_zero_done",  512'(done),  512'(1));
      check_eq("t3_zero_err",   512'(err),   512'(0));
      check_eq("t3_zero_count", 512'(count), 512'(0));
      check_eq("t3_zero_busy",  512'(busy),  512'(0));
      repeat (2) tick();
      send(mk(1, 1), 0);
      check_eq("t3_err_done",   512'(err),   512'(1));
      check_eq("t3_count_done", 512'(count), 512'(0));
      tick();
      check_eq("t3_nwrites", 512'(wq.size()), 512'(0));

      // Reset in the middle of a word
      do_start(8, 10'h040);
      check_eq("t4_err_clr", 512'(err), 512'(0));
      for (int i = 0; i < 5; i++) send(mk(50 + i, 0), 0);
      reset = 1'b1;
      tick();
      check_idle_zero("t4_rst");
      reset = 1'b0;
      repeat (2) tick();
      check_eq("t4_nwrites_rst", 512'(wq.size()), 512'(0));
      do_start(8, 10'h080);
      for (int i = 0; i < 8; i++) send(mk(200 + i, 7), 0);
      repeat (2) tick();
      check_eq("t4_nwrites", 512'(wq.size()), 512'(1));
      check_eq("t4_count",   512'(count), 512'(8));
      check_eq("t4_done",    512'(done),  512'(1));
      for (int k = 0; k < NU; k++) e[k*64 +: 64] = mk(200 + k, 7);
      if (wq.size() > 0) begin
         check_eq("t4_addr", 512'(wq[0].addr), 512'(10'h080));
         check_eq("t4_data", wq[0].data, e);
      end

      // Address wrap
      wq.delete();
      do_start(16, 10'h3FF);
      for (int i = 0; i < 16; i++) send(mk(i, -i), 0);
      repeat (2) tick();
      check_eq("t5_nwrites", 512'(wq.size()), 512'(2));
      for (int k = 0; k < NU; k++) e[k*64 +: 64] = mk(8 + k, -(8 + k));
      if (wq.size() > 1) begin
         check_eq("t5_addr0", 512'(wq[0].addr), 512'(10'h3FF));
         check_eq("t5_addr1", 512'(wq[1].addr), 512'(10'h000));
         check_eq("t5_data1", wq[1].data, e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
